// File: rtl/arm_hazard_pkg.sv
// Shared constants and scoreboard entry layout for the ID-stage hazard scoreboard.
package arm_hazard_pkg;

  localparam int FWD_REGFILE = 0;
  localparam int STALL_CNT_W = 8;

  localparam logic MODE_STALL = 1'b0;
  localparam logic MODE_FWD   = 1'b1;

  // Per-entry control flags; the destination register is kept alongside at REG_ADDR_W bits.
  typedef struct packed {
    logic valid;
    logic wb_en;
    logic is_load;
  } entry_flags_t;

endpackage

// File: rtl/hazard_src_match.sv
// Compares one source operand against every scoreboard entry and picks the youngest producer.
module hazard_src_match
  import arm_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 2,
  parameter int SEL_W      = 2
) (
  input  logic                                en_i,
  input  logic [REG_ADDR_W-1:0]               src_i,
  input  entry_flags_t [DEPTH-1:0]            flags_i,
  input  logic [DEPTH-1:0][REG_ADDR_W-1:0]    dest_i,
  output logic [DEPTH-1:0]                    match_o,
  output logic [SEL_W-1:0]                    sel_o
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign match_o[gi] = en_i & flags_i[gi].valid & flags_i[gi].wb_en &
                           (dest_i[gi] == src_i);
    end
  endgenerate

  // Scan oldest to youngest so the lowest matching index is what remains.
  always_comb begin
    sel_o = SEL_W'(FWD_REGFILE);
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match_o[k]) sel_o = SEL_W'(k + 1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Registered write-back scoreboard with RAW stall / forward-select resolution and a stall watchdog.
module hazard_scoreboard
  import arm_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 2,
  parameter int MAX_STALL  = 15,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_src1,
  input  logic [REG_ADDR_W-1:0]  id_src2,
  input  logic                   id_two_src,
  input  logic [REG_ADDR_W-1:0]  id_dest,
  input  logic                   id_wb_en,
  input  logic                   id_mem_r_en,
  input  logic                   fwd_mode,
  input  logic                   flush,
  output logic                   stall_out,
  output logic [SEL_W-1:0]       fwd_sel_a,
  output logic [SEL_W-1:0]       fwd_sel_b,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   stall_timeout
);

  localparam logic [STALL_CNT_W-1:0] MAX_CNT = STALL_CNT_W'(MAX_STALL);

  entry_flags_t [DEPTH-1:0]         flags_q, flags_d;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] dest_q, dest_d;
  logic [STALL_CNT_W-1:0]           cnt_q, cnt_d;
  logic                             timeout_q, timeout_d;

  logic [DEPTH-1:0] match_a, match_b;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic             any_match, load_use, issue;

  hazard_src_match #(.REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_a (
    .en_i    (id_valid),
    .src_i   (id_src1),
    .flags_i (flags_q),
    .dest_i  (dest_q),
    .match_o (match_a),
    .sel_o   (sel_a)
  );

  hazard_src_match #(.REG_ADDR_W(REG_ADDR_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match_b (
    .en_i    (id_valid & id_two_src),
    .src_i   (id_src2),
    .flags_i (flags_q),
    .dest_i  (dest_q),
    .match_o (match_b),
    .sel_o   (sel_b)
  );

  assign any_match = (|match_a) | (|match_b);
  assign load_use  = (match_a[0] | match_b[0]) & flags_q[0].is_load;
  assign stall_out = (fwd_mode == MODE_STALL) ? any_match : load_use;
  assign issue     = id_valid & ~stall_out;

  assign fwd_sel_a = (fwd_mode == MODE_FWD && !stall_out) ? sel_a : SEL_W'(FWD_REGFILE);
  assign fwd_sel_b = (fwd_mode == MODE_FWD && !stall_out) ? sel_b : SEL_W'(FWD_REGFILE);

  assign stall_count   = cnt_q;
  assign stall_timeout = timeout_q;

  always_comb begin
    flags_d   = flags_q;
    dest_d    = dest_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (flush) begin
      flags_d   = '0;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        flags_d[k] = flags_q[k-1];
        dest_d[k]  = dest_q[k-1];
      end
      // A stalled ID instruction does not enter; a bubble takes its slot.
      flags_d[0].valid   = issue;
      flags_d[0].wb_en   = id_wb_en;
      flags_d[0].is_load = id_mem_r_en;
      dest_d[0]          = id_dest;
      if (stall_out) cnt_d = (cnt_q >= MAX_CNT) ? cnt_q : cnt_q + 1'b1;
      else           cnt_d = '0;
      timeout_d = timeout_q | (cnt_d == MAX_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      flags_q   <= '0;
      dest_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      dest_q    <= dest_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

endmodule
